// File: rtl/adc_stream_emulator.sv
// adc_stream_emulator: serialises four captured 12-bit words MSB first on CS start, timed for the controller's receive chain
module adc_stream_emulator #(
  parameter int   LEAD_CYCLES = 1,
  parameter int   NBITS       = 12,
  parameter logic IDLE_LEVEL  = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ad_cs,
  input  logic [NBITS-1:0] vout_in,
  input  logic [NBITS-1:0] iout_in,
  input  logic [NBITS-1:0] vcap_in,
  input  logic [NBITS-1:0] icap_in,
  input  logic             clear_overrun,
  output logic [1:0]       ad_sdata_a,
  output logic [1:0]       ad_sdata_b,
  output logic             sample_take,
  output logic             busy,
  output logic [7:0]       overrun_cnt
);
  localparam int BW = $clog2(NBITS);
  typedef enum logic [1:0] {IDLE, LEAD, SHIFT} state_t;
  state_t state;
  logic cs_prev;
  logic start;
  logic [3:0] lead_cnt;
  logic [BW-1:0] bit_cnt;
  logic [3:0][NBITS-1:0] sr;
  logic [3:0][NBITS-1:0] sr_sh;
  logic [3:0] msb;
  assign start = ad_cs & ~cs_prev;
  // Word order in sr is {vcap, icap, vout, iout} so msb lines up with {b1, b0, a1, a0}
  always_comb begin
    msb = '0;
    sr_sh = '0;
    for (int i = 0; i < 4; i++) begin
      msb[i] = sr[i][NBITS-1];
      sr_sh[i] = {sr[i][NBITS-2:0], 1'b0};
    end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      cs_prev <= 1'b0;
      lead_cnt <= '0;
      bit_cnt <= '0;
      sr <= '0;
      {ad_sdata_b, ad_sdata_a} <= {4{IDLE_LEVEL}};
      sample_take <= 1'b0;
      busy <= 1'b0;
      overrun_cnt <= '0;
    end else begin
      cs_prev <= ad_cs;
      sample_take <= 1'b0;
      if (clear_overrun)
        overrun_cnt <= '0;
      else if (start && state != IDLE && overrun_cnt != 8'hff)
        overrun_cnt <= overrun_cnt + 8'd1;
      case (state)
        IDLE:
          if (start) begin
            sr <= {vcap_in, icap_in, vout_in, iout_in};
            sample_take <= 1'b1;
            lead_cnt <= 4'(LEAD_CYCLES - 1);
            busy <= 1'b1;
            state <= LEAD;
          end
        LEAD:
          if (lead_cnt == '0) begin
            {ad_sdata_b, ad_sdata_a} <= msb;
            sr <= sr_sh;
            bit_cnt <= BW'(NBITS - 1);
            state <= SHIFT;
          end else
            lead_cnt <= lead_cnt - 4'd1;
        SHIFT:
          if (bit_cnt == '0) begin
            {ad_sdata_b, ad_sdata_a} <= {4{IDLE_LEVEL}};
            busy <= 1'b0;
            state <= IDLE;
          end else begin
            {ad_sdata_b, ad_sdata_a} <= msb;
            sr <= sr_sh;
            bit_cnt <= bit_cnt - BW'(1);
          end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_adc_stream_emulator.sv
// tb_adc_stream_emulator: random and directed stimulus against an edge-indexed model, for default and LEAD=3/IDLE=1 instances
module tb_adc_stream_emulator;
  logic clk = 1'b0, reset = 1'b1, ad_cs = 1'b0, clear_overrun = 1'b0;
  logic [11:0] vout_in = '0, iout_in = '0, vcap_in = '0, icap_in = '0;
  logic [1:0] a0, b0, a1, b1;
  logic st0, st1, bz0, bz1;
  logic [7:0] ov0, ov1;
  int compared = 0, mismatched = 0;
  int tk [2] = '{0, 0};
  always #5 clk = ~clk;

  adc_stream_emulator dut0 (
    .clk(clk), .reset(reset), .ad_cs(ad_cs), .vout_in(vout_in), .iout_in(iout_in),
    .vcap_in(vcap_in), .icap_in(icap_in), .clear_overrun(clear_overrun),
    .ad_sdata_a(a0), .ad_sdata_b(b0), .sample_take(st0), .busy(bz0), .overrun_cnt(ov0));
  adc_stream_emulator #(.LEAD_CYCLES(3), .IDLE_LEVEL(1'b1)) dut1 (
    .clk(clk), .reset(reset), .ad_cs(ad_cs), .vout_in(vout_in), .iout_in(iout_in),
    .vcap_in(vcap_in), .icap_in(icap_in), .clear_overrun(clear_overrun),
    .ad_sdata_a(a1), .ad_sdata_b(b1), .sample_take(st1), .busy(bz1), .overrun_cnt(ov1));

  function automatic int lead(int j);
    return (j != 0) ? 3 : 1;
  endfunction

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask

  // Model: remember the accepted start edge and captured words; everything else follows from edge arithmetic
  int cyc = 0;
  bit m_act [2] = '{0, 0};
  bit m_csp [2] = '{0, 0};
  int m_s [2] = '{0, 0};
  int m_take [2] = '{-100, -100};
  int m_ovr [2] = '{0, 0};
  logic [11:0] m_w [2][4];

  always @(posedge clk or posedge reset) begin
    bit st, bb;
    if (reset) begin
      for (int j = 0; j < 2; j++) begin
        m_act[j] = 0; m_csp[j] = 0; m_take[j] = -100; m_ovr[j] = 0;
      end
    end else begin
      for (int j = 0; j < 2; j++) begin
        st = ad_cs && !m_csp[j];
        bb = m_act[j] && (cyc - 1 - m_s[j]) <= lead(j) + 11;
        if (st && bb)
          m_ovr[j] = (m_ovr[j] == 255) ? 255 : m_ovr[j] + 1;
        else if (st) begin
          m_act[j] = 1; m_s[j] = cyc; m_take[j] = cyc;
          m_w[j] = '{vcap_in, icap_in, vout_in, iout_in};
        end
        if (clear_overrun) m_ovr[j] = 0;
        m_csp[j] = ad_cs;
      end
      cyc++;
    end
  end

  always @(negedge clk) begin
    int d, L, i;
    bit eb;
    logic [3:0] el, al;
    #1;
    for (int j = 0; j < 2; j++) begin
      L = lead(j);
      d = cyc - 1 - m_s[j];
      eb = m_act[j] && d >= 0 && d <= L + 11;
      el = (j != 0) ? 4'hf : 4'h0;
      if (eb && d >= L) begin
        i = L + 11 - d;
        el = {m_w[j][0][i], m_w[j][1][i], m_w[j][2][i], m_w[j][3][i]};
      end
      al = (j != 0) ? {b1, a1} : {b0, a0};
      chk($sformatf("lines%0d", j), al, el);
      chk($sformatf("busy%0d", j), (j != 0) ? bz1 : bz0, eb);
      chk($sformatf("take%0d", j), (j != 0) ? st1 : st0, m_take[j] == cyc - 1);
      chk($sformatf("ovr%0d", j), (j != 0) ? ov1 : ov0, m_ovr[j]);
      tk[j] += (j != 0) ? int'(st1) : int'(st0);
    end
  end

  task automatic tick;
    @(negedge clk);
    #2;
  endtask

  task automatic rnd_in;
    vout_in = 12'($urandom); iout_in = 12'($urandom);
    vcap_in = 12'($urandom); icap_in = 12'($urandom);
  endtask

  task automatic idle(input int n);
    ad_cs = 0;
    for (int k = 0; k < n; k++) tick;
  endtask

  initial begin
    logic [11:0] cv [2][4];
    int t0, t1;
    tick; tick;
    chk("rst_lines0", {b0, a0}, 4'h0);
    chk("rst_lines1", {b1, a1}, 4'hf);
    chk("rst_busy", {bz0, bz1, st0, st1}, 4'h0);
    chk("rst_ovr", {ov0, ov1}, 16'h0);
    reset = 0;
    idle(3);
    // Single pulse with the reference values
    vcap_in = 12'h320; icap_in = 12'h0F0; vout_in = 12'h0A5; iout_in = 12'hF00;
    t0 = tk[0]; t1 = tk[1];
    ad_cs = 1;
    for (int k = 0; k <= 16; k++) begin
      tick;
      if (k == 0) begin ad_cs = 0; rnd_in; end
      for (int j = 0; j < 2; j++)
        if (k >= lead(j) && k <= lead(j) + 11) begin
          cv[j][0][lead(j) + 11 - k] = (j != 0) ? b1[1] : b0[1];
          cv[j][1][lead(j) + 11 - k] = (j != 0) ? b1[0] : b0[0];
          cv[j][2][lead(j) + 11 - k] = (j != 0) ? a1[1] : a0[1];
          cv[j][3][lead(j) + 11 - k] = (j != 0) ? a1[0] : a0[0];
        end
      if (k == 0) chk("sp_idle_k0", {b0, a0}, 4'h0);
      if (k == 2) chk("sp_idle1_k2", {b1, a1}, 4'hf);
      if (k == 12) chk("sp_busy_k12", bz0, 1'b1);
      if (k == 13) chk("sp_busy_k13", {bz0, b0, a0}, 5'h0);
      if (k == 14) chk("sp_busy1_k14", bz1, 1'b1);
      if (k == 15) chk("sp_busy1_k15", {bz1, b1, a1}, 5'h0f);
    end
    for (int j = 0; j < 2; j++) begin
      chk($sformatf("sp_vcap%0d", j), cv[j][0], 12'h320);
      chk($sformatf("sp_icap%0d", j), cv[j][1], 12'h0F0);
      chk($sformatf("sp_vout%0d", j), cv[j][2], 12'h0A5);
      chk($sformatf("sp_iout%0d", j), cv[j][3], 12'hF00);
    end
    chk("sp_takes", {tk[0] - t0, tk[1] - t1}, {32'd1, 32'd1});
    // Overrun at E5, then overrun with simultaneous clear
    for (int r = 0; r < 2; r++) begin
      idle(4);
      t0 = tk[0]; t1 = tk[1];
      ad_cs = 1;
      for (int k = 0; k < 20; k++) begin
        tick;
        ad_cs = (k == 4);
        clear_overrun = (k == 4) && (r == 1);
        if (k == 0) rnd_in;
      end
      chk($sformatf("ovr_cnt%0d", r), {ov0, ov1}, (r == 0) ? 16'h0101 : 16'h0000);
      chk($sformatf("ovr_takes%0d", r), {tk[0] - t0, tk[1] - t1}, {32'd1, 32'd1});
    end
    // Long CS
    t0 = tk[0]; t1 = tk[1];
    ad_cs = 1;
    for (int k = 0; k < 40; k++) tick;
    idle(20);
    chk("long_takes", {tk[0] - t0, tk[1] - t1}, {32'd1, 32'd1});
    chk("long_ovr", {ov0, ov1}, 16'h0);
    // Reset mid-shift
    rnd_in;
    ad_cs = 1;
    for (int k = 0; k <= 6; k++) begin tick; ad_cs = 0; end
    reset = 1;
    #1;
    chk("rms_lines", {b1, a1, b0, a0}, 8'hf0);
    chk("rms_busy", {bz0, bz1}, 2'b00);
    tick; reset = 0;
    idle(3);
    rnd_in; ad_cs = 1; tick; ad_cs = 0; rnd_in;
    idle(20);
    // Saturation
    for (int k = 0; k < 800; k++) begin ad_cs = ~ad_cs; rnd_in; tick; end
    chk("sat", {ov0, ov1}, 16'hffff);
    idle(20);
    // Controller-like 16-cycle frames
    for (int f = 0; f < 20; f++) begin
      rnd_in; ad_cs = 1; tick; ad_cs = 0;
      for (int k = 0; k < 15; k++) begin tick; if (k == 0) rnd_in; end
    end
    // Random
    for (int k = 0; k < 3000; k++) begin
      ad_cs = ($urandom_range(0, 5) == 0) ? ~ad_cs : ad_cs;
      clear_overrun = ($urandom_range(0, 40) == 0);
      reset = ($urandom_range(0, 400) == 0);
      if ($urandom_range(0, 2) == 0) rnd_in;
      tick;
    end
    reset = 0; clear_overrun = 0;
    idle(20);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
